// File: rtl/movegen_seq.sv
// movegen_seq: walks the board arbiter to enumerate captures, most valuable victim first,
// emitting each (from,to) move over a valid/ready stream.
module movegen_seq #(
    parameter int         SETTLE        = 2,
    parameter logic [2:0] MODE_IDLE     = 3'd0,
    parameter logic [2:0] MODE_VICTIM   = 3'd1,
    parameter logic [2:0] MODE_ATTACKER = 3'd2,
    parameter logic [1:0] MASK_NONE     = 2'd0,
    parameter logic [1:0] MASK_VICTIM   = 2'd1,
    parameter logic [1:0] MASK_ATTACKER = 2'd2,
    parameter logic [1:0] MASK_CLEAR    = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       start_wtm,
    input  logic       abort,
    output logic [2:0] state_mode,
    output logic [1:0] mask_mode,
    output logic       wtm,
    output logic [3:0] write_bus,
    output logic [5:0] ss1,
    output logic       ss1_valid,
    output logic [5:0] ss2,
    output logic       ss2_valid,
    input  logic [6:0] board_data,
    input  logic       board_illegal,
    output logic       mv_valid,
    input  logic       mv_ready,
    output logic [5:0] mv_from,
    output logic [5:0] mv_to,
    output logic       busy,
    output logic       done,
    output logic       illegal
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, CLR, VSCAN, ASCAN, EMIT, MASKA, MASKV, FIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          first;
    logic [5:0]    victim, attacker;
    logic          sample, found;

    assign sample = cnt == '0;
    assign found  = board_data[6];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start && !abort ? CLR : IDLE;
            CLR:   state_nx = VSCAN;
            VSCAN: state_nx = !sample ? VSCAN : ((first && board_illegal) || !found) ? FIN : ASCAN;
            ASCAN: state_nx = !sample ? ASCAN : found ? EMIT : MASKV;
            EMIT:  state_nx = mv_ready ? MASKA : EMIT;
            MASKA: state_nx = ASCAN;
            MASKV: state_nx = VSCAN;
            FIN:   state_nx = IDLE;
        endcase
        // FIN always returns to IDLE so a late abort cannot produce a second done pulse
        if (abort && state != IDLE && state != FIN)
            state_nx = FIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= CW'(SETTLE);
            first    <= 1'b0;
            victim   <= '0;
            attacker <= '0;
            wtm      <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? CW'(SETTLE) : sample ? cnt : cnt - CW'(1);
            if (state == IDLE && state_nx == CLR) begin
                wtm     <= start_wtm;
                illegal <= 1'b0;
                first   <= 1'b1;
            end
            if (state == VSCAN && sample) begin
                first <= 1'b0;
                if (first && board_illegal && !abort)
                    illegal <= 1'b1;
            end
            if (state == VSCAN && state_nx == ASCAN)
                victim <= board_data[5:0];
            if (state == ASCAN && state_nx == EMIT)
                attacker <= board_data[5:0];
        end
    end

    assign state_mode = state == VSCAN ? MODE_VICTIM : state == ASCAN ? MODE_ATTACKER : MODE_IDLE;
    assign mask_mode  = (state == CLR || state == FIN) ? MASK_CLEAR :
                        state == MASKA ? MASK_ATTACKER : state == MASKV ? MASK_VICTIM : MASK_NONE;
    assign write_bus  = 4'b0;
    assign ss1        = victim;
    assign ss1_valid  = state == ASCAN || state == MASKV;
    assign ss2        = attacker;
    assign ss2_valid  = state == MASKA;
    assign mv_valid   = state == EMIT;
    assign mv_from    = attacker;
    assign mv_to      = victim;
    assign busy       = state != IDLE;
    assign done       = state == FIN;
endmodule

// File: tb/tb_movegen_seq.sv
// tb_movegen_seq: behavioural board plus expected-move queue checking movegen_seq.
module tb_movegen_seq;
    logic       clk = 0, rst_n = 0, start = 0, start_wtm = 0, abort = 0;
    logic       board_illegal = 0, mv_ready = 1;
    logic [6:0] board_data = '0;
    logic [2:0] state_mode;
    logic [1:0] mask_mode;
    logic       wtm, ss1_valid, ss2_valid, mv_valid, busy, done, illegal;
    logic [3:0] write_bus;
    logic [5:0] ss1, ss2, mv_from, mv_to;

    int checks = 0, errs = 0, xfers = 0, holds = 0, stall = 0;
    bit ready_def = 1, aborted = 0, hold_pend = 0;
    logic [5:0] hf, ht;
    int q[$];

    int nv = 0;
    int vsq[4];
    int na[4];
    int asq[4][4];
    bit vmask[64];
    bit amask[64];

    always #5 clk = ~clk;

    movegen_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_wtm(start_wtm), .abort(abort),
        .state_mode(state_mode), .mask_mode(mask_mode), .wtm(wtm), .write_bus(write_bus),
        .ss1(ss1), .ss1_valid(ss1_valid), .ss2(ss2), .ss2_valid(ss2_valid),
        .board_data(board_data), .board_illegal(board_illegal),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
        .busy(busy), .done(done), .illegal(illegal)
    );

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Board: victims listed most valuable first, attackers least valuable first.
    function automatic logic [6:0] arb();
        if (state_mode == 3'd1) begin
            for (int i = 0; i < nv; i++)
                if (!vmask[vsq[i]]) return {1'b1, 6'(vsq[i])};
        end else if (state_mode == 3'd2) begin
            for (int i = 0; i < nv; i++)
                if (vsq[i] == int'(ss1))
                    for (int j = 0; j < na[i]; j++)
                        if (!amask[asq[i][j]]) return {1'b1, 6'(asq[i][j])};
        end
        return '0;
    endfunction

    always @(posedge clk) begin
        board_data <= arb();
        if (mask_mode == 2'd3) begin
            foreach (vmask[i]) vmask[i] = 0;
            foreach (amask[i]) amask[i] = 0;
        end
        if (mask_mode == 2'd1) vmask[ss1] = 1;
        if (mask_mode == 2'd2) amask[ss2] = 1;
    end

    always @(posedge clk) begin
        #1;
        if (mv_valid && stall > 0) begin
            mv_ready = 0;
            stall--;
        end else mv_ready = ready_def;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
            q.delete();
        end else begin
            if (hold_pend) begin
                holds++;
                chk("hold_valid", mv_valid, 1);
                chk("hold_from", mv_from, hf);
                chk("hold_to", mv_to, ht);
            end
            hold_pend = mv_valid && !mv_ready && !abort;
            hf = mv_from;
            ht = mv_to;
            if (mv_valid) chk("valid_implies_busy", busy, 1);
            if (mv_valid && mv_ready) begin
                xfers++;
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_move: got (%0d,%0d) expected none", mv_from, mv_to);
                end else begin
                    int e;
                    e = q.pop_front();
                    chk("mv_from", mv_from, e / 64);
                    chk("mv_to", mv_to, e % 64);
                end
            end
            if (done) begin
                if (!aborted) chk("moves_left_at_done", q.size(), 0);
                q.delete();
            end
        end
    end

    task automatic build_exp();
        q.delete();
        aborted = 0;
        for (int i = 0; i < nv; i++)
            for (int j = 0; j < na[i]; j++)
                q.push_back(asq[i][j] * 64 + vsq[i]);
    endtask

    task automatic kick();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("clr_mask", mask_mode, 3);
                chk("busy_after_start", busy, 1);
                chk("illegal_cleared", illegal, 0);
            end
            if (done) break;
        end
        if (!done) chk("done_timeout", k, 0);
        @(negedge clk);
        chk("busy_drop", busy, 0);
    endtask

    int k, x0, h0;

    initial begin
        #12;
        chk("rst_state_mode", state_mode, 0);
        chk("rst_mask_mode", mask_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mv_valid", mv_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ss1_valid", ss1_valid, 0);
        chk("rst_ss2_valid", ss2_valid, 0);
        chk("rst_mv_from", mv_from, 0);
        @(posedge clk); #1 rst_n = 1;

        nv = 0; build_exp(); x0 = xfers;
        kick(); wait_done(k);
        chk("empty_done_latency", k, 5);
        chk("empty_no_moves", xfers - x0, 0);
        chk("write_bus", write_bus, 0);

        nv = 1; vsq[0] = 35; na[0] = 2; asq[0][0] = 12; asq[0][1] = 20;
        build_exp();
        chk("model_len", q.size(), 2);
        chk("model_first", q[0], 12 * 64 + 35);
        chk("model_second", q[1], 20 * 64 + 35);
        start_wtm = 1; x0 = xfers;
        kick(); wait_done(k);
        chk("two_moves", xfers - x0, 2);
        chk("wtm_latched", wtm, 1);

        build_exp(); start_wtm = 0; x0 = xfers; h0 = holds; stall = 5;
        kick(); wait_done(k);
        chk("stall_moves", xfers - x0, 2);
        chk("stall_hold_cycles", holds - h0, 5);
        chk("wtm_latched0", wtm, 0);

        nv = 2; vsq[0] = 40; na[0] = 2; asq[0][0] = 7; asq[0][1] = 9;
        vsq[1] = 35; na[1] = 1; asq[1][0] = 12;
        build_exp(); x0 = xfers;
        kick(); wait_done(k);
        chk("two_victim_moves", xfers - x0, 3);

        nv = 1; vsq[0] = 35; na[0] = 1; asq[0][0] = 12;
        q.delete(); aborted = 0; board_illegal = 1; x0 = xfers;
        kick(); wait_done(k);
        chk("illegal_set", illegal, 1);
        chk("illegal_latency", k, 5);
        chk("illegal_no_moves", xfers - x0, 0);
        board_illegal = 0; nv = 0; build_exp();
        kick(); wait_done(k);
        chk("illegal_after_restart", illegal, 0);

        nv = 1; build_exp(); aborted = 1;
        kick();
        for (int i = 0; i < 50 && state_mode != 3'd2; i++) @(negedge clk);
        chk("reach_ascan", state_mode, 2);
        @(posedge clk); #2 abort = 1;
        @(negedge clk);
        @(negedge clk);
        chk("abortA_valid", mv_valid, 0);
        chk("abortA_mask", mask_mode, 3);
        chk("abortA_done", done, 1);
        @(posedge clk); #2 abort = 0;
        @(negedge clk);
        chk("abortA_idle", busy, 0);

        build_exp(); aborted = 1; ready_def = 0; x0 = xfers;
        kick();
        for (int i = 0; i < 50 && !mv_valid; i++) @(negedge clk);
        chk("reach_emit", mv_valid, 1);
        ready_def = 1;
        @(posedge clk); #2 abort = 1;
        @(negedge clk);
        @(negedge clk);
        chk("abortE_valid", mv_valid, 0);
        chk("abortE_mask", mask_mode, 3);
        chk("abortE_done", done, 1);
        chk("abortE_accepted", xfers - x0, 1);
        @(posedge clk); #2 abort = 0;
        @(negedge clk);
        chk("abortE_idle", busy, 0);

        @(posedge clk); #1 start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        @(negedge clk);
        chk("start_abort_idle", busy, 0);

        build_exp(); ready_def = 0;
        kick();
        for (int i = 0; i < 50 && !mv_valid; i++) @(negedge clk);
        chk("reach_emit2", mv_valid, 1);
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("arst_valid", mv_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mode", state_mode, 0);
        chk("arst_mv_to", mv_to, 0);
        chk("arst_ss1_valid", ss1_valid, 0);
        @(posedge clk); #1 rst_n = 1; ready_def = 1;
        build_exp(); x0 = xfers;
        kick(); wait_done(k);
        chk("post_reset_moves", xfers - x0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
